// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - execute-stage ALU with multi-cycle multiply/divide into HI/LO
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] Output,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [5:0] OP_SLL   = 6'd0;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_SRA   = 6'd3;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIV   = 6'd26;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_SLTU  = 6'd43;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     hi, lo;
    logic [SHW-1:0]       cnt;
    logic                 op_div, neg_lo, neg_hi;

    logic                 is_md, is_div, sgn_op, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b, alu_res;
    logic [SHW-1:0]       shamt;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   acc_step, prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;

    assign busy   = (state != IDLE);
    assign is_md  = (Signal == OP_MULT) || (Signal == OP_MULTU) ||
                    (Signal == OP_DIV)  || (Signal == OP_DIVU);
    assign is_div = (Signal == OP_DIV) || (Signal == OP_DIVU);
    assign sgn_op = (Signal == OP_MULT) || (Signal == OP_DIV);
    assign a_neg  = sgn_op & dataA[WIDTH-1];
    assign b_neg  = sgn_op & dataB[WIDTH-1];
    assign b_zero = (dataB == '0);
    assign mag_a  = a_neg ? -dataA : dataA;
    assign mag_b  = b_neg ? -dataB : dataB;
    assign shamt  = dataB[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (Signal)
            OP_AND:  alu_res = dataA & dataB;
            OP_OR:   alu_res = dataA | dataB;
            OP_ADD:  alu_res = dataA + dataB;
            OP_SUB:  alu_res = dataA - dataB;
            OP_SLT:  alu_res = WIDTH'($signed(dataA) < $signed(dataB));
            OP_SLTU: alu_res = WIDTH'(dataA < dataB);
            OP_SLL:  alu_res = dataA << shamt;
            OP_SRL:  alu_res = dataA >> shamt;
            OP_SRA:  alu_res = $signed(dataA) >>> shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        if (op_div) begin
            if (div_trial[WIDTH])
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
        prod_fix = neg_lo ? -acc : acc;
        q_fix    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && is_md) state_nxt = RUN;
            RUN:     if (cnt == SHW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Output   <= '0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_md) begin
                            // Divide by zero runs unsigned on raw A: the restoring loop then yields
                            // an all-ones quotient and remainder A with no special case.
                            acc    <= {{WIDTH{1'b0}}, (is_div && b_zero) ? dataA : mag_a};
                            opb    <= mag_b;
                            cnt    <= '0;
                            op_div <= is_div;
                            neg_lo <= (is_div && b_zero) ? 1'b0 : (a_neg ^ b_neg);
                            neg_hi <= is_div ? (!b_zero && a_neg) : 1'b0;
                            if (is_div) div_zero <= b_zero;
                        end else begin
                            Output <= alu_res;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (op_div) begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
